node_port: RTL and testbench

Processor-side endpoint of the router core's node interface: drives Packet_From_Node / Packet_From_Node_Valid into router_core and consumes Packet_To_Node / Packet_To_Node_Valid from it. It buffers outbound packets from the local processor and inbound payloads to the processor. It replaces the forced node stimulus used in ring-level benches. One instance sits beside each router_core, all on the core clock.

---
 rtl/node_port.sv | 177 +++++++++++++++++
 tb/tb_node_port.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/node_port.sv
`default_nettype none
// ============================================================================
// Module : node_port
// Processor-side endpoint of the router_core node interface: an outbound
// packet FIFO with a handshake FSM toward the core and an inbound payload FIFO.
// Rev    : 1.0  initial release
// ============================================================================
module node_port #(
  parameter logic [3:0] MY_ADDR   = 4'b0000,
  parameter int         TX_DEPTH  = 4,
  parameter int         RX_DEPTH  = 4,
  parameter logic [7:0] STALL_CYC = 8'd255
) (
  input  logic        Clk_R,
  input  logic        Rst,
  input  logic        Send_Req,
  input  logic [3:0]  Send_Addr,
  input  logic        Send_Type,
  input  logic [23:0] Send_Data,
  output logic        Send_Ready,
  output logic        Send_Err,
  output logic [28:0] Packet_From_Node,
  output logic        Packet_From_Node_Valid,
  input  logic        Core_Load_Ack,
  input  logic [23:0] Packet_To_Node,
  input  logic        Packet_To_Node_Valid,
  output logic        Rx_Valid,
  output logic [23:0] Rx_Data,
  input  logic        Rx_Pop,
  output logic        Tx_Stall,
  output logic        Rx_Ovf,
  output logic [7:0]  Tx_Count,
  output logic [7:0]  Rx_Count
);

  localparam int         TAW     = $clog2(TX_DEPTH);
  localparam int         RAW     = $clog2(RX_DEPTH);
  localparam logic [TAW:0] TX_ONE = 1;
  localparam logic [RAW:0] RX_ONE = 1;
  localparam logic [RAW-1:0] RX_IDX_ONE = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

  tx_state_t     state;

  logic [28:0]   tx_mem [TX_DEPTH];
  logic [TAW:0]  tx_wr;
  logic [TAW:0]  tx_rd;
  logic          tx_empty;
  logic          tx_full;
  logic          tx_push;
  logic          tx_pop;
  logic [7:0]    stall_cnt;
  logic [7:0]    stall_next;

  logic [23:0]   rx_mem [RX_DEPTH];
  logic [RAW:0]  rx_wr;
  logic [RAW:0]  rx_rd;
  logic [RAW:0]  rx_cnt;
  logic [RAW-1:0] rx_next_idx;
  logic          rx_empty;
  logic          rx_full;
  logic          rx_push;
  logic          rx_pop;
  logic          rx_drop;

  // ---------------------------------------------------------------- TX FIFO
  assign tx_empty   = (tx_wr == tx_rd);
  assign tx_full    = (tx_wr[TAW] != tx_rd[TAW]) && (tx_wr[TAW-1:0] == tx_rd[TAW-1:0]);
  assign tx_push    = Send_Req && !tx_full && (Send_Addr != MY_ADDR);
  assign tx_pop     = (state == OFFER) && Core_Load_Ack;
  assign Send_Ready = !tx_full;
  assign stall_next = (stall_cnt == 8'hFF) ? 8'hFF : stall_cnt + 8'd1;

  always_ff @(posedge Clk_R) begin
    if (tx_push) begin
      tx_mem[tx_wr[TAW-1:0]] <= {Send_Addr, Send_Type, Send_Data};
    end
  end

  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      Send_Err <= 1'b0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + TX_ONE;
      if (tx_pop)  tx_rd <= tx_rd + TX_ONE;
      Send_Err <= Send_Req && !tx_push;
    end
  end

  // GAP holds Valid low until the core drops its ack, guaranteeing a Valid edge per packet
  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      state                  <= IDLE;
      Packet_From_Node_Valid <= 1'b0;
      Packet_From_Node       <= '0;
      stall_cnt              <= '0;
      Tx_Stall               <= 1'b0;
      Tx_Count               <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!tx_empty && !Core_Load_Ack) begin
            state                  <= OFFER;
            Packet_From_Node_Valid <= 1'b1;
            Packet_From_Node       <= tx_mem[tx_rd[TAW-1:0]];
          end
        end
        OFFER: begin
          if (Core_Load_Ack) begin
            state                  <= GAP;
            Packet_From_Node_Valid <= 1'b0;
            Packet_From_Node       <= '0;
            stall_cnt              <= '0;
            Tx_Stall               <= 1'b0;
            if (Tx_Count != 8'hFF) Tx_Count <= Tx_Count + 8'd1;
          end else begin
            stall_cnt <= stall_next;
            Tx_Stall  <= (stall_next >= STALL_CYC);
          end
        end
        GAP: begin
          if (!Core_Load_Ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  assign rx_cnt      = rx_wr - rx_rd;
  assign rx_empty    = (rx_wr == rx_rd);
  assign rx_full     = (rx_wr[RAW] != rx_rd[RAW]) && (rx_wr[RAW-1:0] == rx_rd[RAW-1:0]);
  assign rx_pop      = Rx_Pop && !rx_empty;
  assign rx_push     = Packet_To_Node_Valid && (!rx_full || rx_pop);
  assign rx_drop     = Packet_To_Node_Valid && !rx_push;
  assign rx_next_idx = rx_rd[RAW-1:0] + RX_IDX_ONE;
  assign Rx_Valid    = !rx_empty;

  always_ff @(posedge Clk_R) begin
    if (rx_push) begin
      rx_mem[rx_wr[RAW-1:0]] <= Packet_To_Node;
    end
  end

  // Rx_Data is a registered copy of the head, refreshed with whatever becomes head after this edge
  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      Rx_Data  <= '0;
      Rx_Ovf   <= 1'b0;
      Rx_Count <= '0;
    end else begin
      if (rx_push) begin
        rx_wr <= rx_wr + RX_ONE;
        if (Rx_Count != 8'hFF) Rx_Count <= Rx_Count + 8'd1;
      end
      if (rx_pop) rx_rd <= rx_rd + RX_ONE;
      if (rx_drop) Rx_Ovf <= 1'b1;
      if (rx_pop) begin
        if (rx_cnt > RX_ONE)  Rx_Data <= rx_mem[rx_next_idx];
        else if (rx_push)     Rx_Data <= Packet_To_Node;
      end else if (rx_empty && rx_push) begin
        Rx_Data <= Packet_To_Node;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_node_port.sv
`default_nettype none
// ============================================================================
// Module : tb_node_port
// Self-checking bench for node_port: vector table, directed corner sequences
// and randomized traffic against a queue-based reference model.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_node_port;

  localparam int TXD   = 4;
  localparam int RXD   = 4;
  localparam int STALL = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [3:0]  addr = '0;
  logic        typ = 1'b0;
  logic [23:0] sdata = '0;
  logic        ack = 1'b0;
  logic [23:0] ptn = '0;
  logic        ptnv = 1'b0;
  logic        pop = 1'b0;

  logic        ready, err, valid, rxv, stall, ovf;
  logic [28:0] pkt;
  logic [23:0] rxd;
  logic [7:0]  txc, rxc;

  always #5 clk = ~clk;

  node_port #(
    .MY_ADDR(4'b0000), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .STALL_CYC(8'd10)
  ) dut (
    .Clk_R(clk), .Rst(rst),
    .Send_Req(req), .Send_Addr(addr), .Send_Type(typ), .Send_Data(sdata),
    .Send_Ready(ready), .Send_Err(err),
    .Packet_From_Node(pkt), .Packet_From_Node_Valid(valid),
    .Core_Load_Ack(ack),
    .Packet_To_Node(ptn), .Packet_To_Node_Valid(ptnv),
    .Rx_Valid(rxv), .Rx_Data(rxd), .Rx_Pop(pop),
    .Tx_Stall(stall), .Rx_Ovf(ovf), .Tx_Count(txc), .Rx_Count(rxc)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: packet queues plus an "offering / waiting for release" view of the port
  logic [28:0] m_txq[$];
  logic [23:0] m_rxq[$];
  bit          m_offer, m_gap, m_ovf, m_err;
  int          m_age, m_txc, m_rxc;

  task automatic model_reset();
    m_txq.delete();
    m_rxq.delete();
    m_offer = 0; m_gap = 0; m_ovf = 0; m_err = 0;
    m_age = 0; m_txc = 0; m_rxc = 0;
  endtask

  task automatic model_edge();
    bit          was_full, pop_e, accept;
    logic [28:0] d29;
    logic [23:0] d24;
    if (rst) begin
      model_reset();
      return;
    end
    was_full = (m_txq.size() == TXD);
    pop_e    = pop && (m_rxq.size() > 0);
    if (m_offer) begin
      if (ack) begin
        d29 = m_txq.pop_front();
        m_txc = (m_txc < 255) ? m_txc + 1 : 255;
        m_offer = 0; m_gap = 1; m_age = 0;
      end else if (m_age < 255) begin
        m_age++;
      end
    end else if (m_gap) begin
      if (!ack) m_gap = 0;
    end else if (m_txq.size() > 0 && !ack) begin
      m_offer = 1; m_age = 0;
    end
    m_err = req && (was_full || addr == 4'h0);
    if (req && !m_err) m_txq.push_back({addr, typ, sdata});
    accept = ptnv && ((m_rxq.size() < RXD) || pop_e);
    if (ptnv && !accept) m_ovf = 1;
    if (pop_e) d24 = m_rxq.pop_front();
    if (accept) begin
      m_rxq.push_back(ptn);
      m_rxc = (m_rxc < 255) ? m_rxc + 1 : 255;
    end
  endtask

  task automatic model_compare();
    check("valid", 32'(valid), 32'(m_offer));
    if (m_offer) check("pkt", 32'(pkt), 32'(m_txq[0]));
    check("send_ready", 32'(ready), 32'(m_txq.size() < TXD));
    check("send_err", 32'(err), 32'(m_err));
    check("tx_stall", 32'(stall), 32'(m_offer && m_age >= STALL));
    check("tx_count", 32'(txc), 32'(m_txc));
    check("rx_valid", 32'(rxv), 32'(m_rxq.size() > 0));
    if (m_rxq.size() > 0) check("rx_data", 32'(rxd), 32'(m_rxq[0]));
    check("rx_ovf", 32'(ovf), 32'(m_ovf));
    check("rx_count", 32'(rxc), 32'(m_rxc));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_compare();
  endtask

  task automatic set_idle();
    req = 0; ack = 0; ptnv = 0; pop = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pkt"},   32'(pkt),   32'h0);
    check({tag, "_valid"}, 32'(valid), 32'h0);
    check({tag, "_ready"}, 32'(ready), 32'h1);
    check({tag, "_err"},   32'(err),   32'h0);
    check({tag, "_rxv"},   32'(rxv),   32'h0);
    check({tag, "_rxd"},   32'(rxd),   32'h0);
    check({tag, "_stall"}, 32'(stall), 32'h0);
    check({tag, "_ovf"},   32'(ovf),   32'h0);
    check({tag, "_txc"},   32'(txc),   32'h0);
    check({tag, "_rxc"},   32'(rxc),   32'h0);
  endtask

  typedef struct packed {
    logic        req;
    logic [3:0]  addr;
    logic [23:0] data;
    logic        ack;
    logic        e_valid;
    logic [28:0] e_pkt;
    logic        e_ready;
    logic        e_err;
    logic [7:0]  e_txc;
  } vec_t;

  vec_t vt [10];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int          waited;
    int          ack_pct;
    logic [23:0] exp_order [4];
    logic [23:0] exp_drain [3];

    // Single packet: offer, ack held 3 cycles, then a self-addressed send
    vt[0] = '{1'b1, 4'h1, 24'd42, 1'b0, 1'b0, 29'h0,        1'b1, 1'b0, 8'd0};
    vt[1] = '{1'b0, 4'h0, 24'd0,  1'b0, 1'b1, 29'h0200002A, 1'b1, 1'b0, 8'd0};
    vt[2] = '{1'b0, 4'h0, 24'd0,  1'b1, 1'b0, 29'h0,        1'b1, 1'b0, 8'd1};
    vt[3] = '{1'b0, 4'h0, 24'd0,  1'b1, 1'b0, 29'h0,        1'b1, 1'b0, 8'd1};
    vt[4] = '{1'b0, 4'h0, 24'd0,  1'b1, 1'b0, 29'h0,        1'b1, 1'b0, 8'd1};
    vt[5] = '{1'b0, 4'h0, 24'd0,  1'b0, 1'b0, 29'h0,        1'b1, 1'b0, 8'd1};
    vt[6] = '{1'b0, 4'h0, 24'd0,  1'b0, 1'b0, 29'h0,        1'b1, 1'b0, 8'd1};
    vt[7] = '{1'b1, 4'h0, 24'd69, 1'b0, 1'b0, 29'h0,        1'b1, 1'b1, 8'd1};
    vt[8] = '{1'b0, 4'h0, 24'd0,  1'b0, 1'b0, 29'h0,        1'b1, 1'b0, 8'd1};
    vt[9] = '{1'b0, 4'h0, 24'd0,  1'b0, 1'b0, 29'h0,        1'b1, 1'b0, 8'd1};
    exp_order = '{24'd42, 24'd100, 24'd1, 24'd2};
    exp_drain = '{24'h47, 24'h48, 24'h50};

    model_reset();
    set_idle();
    rst = 1;
    step();
    rst = 0;
    check_reset_values("reset");

    for (int i = 0; i < 10; i++) begin
      req = vt[i].req; addr = vt[i].addr; typ = 1'b0; sdata = vt[i].data; ack = vt[i].ack;
      step();
      check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vt[i].e_valid));
      if (vt[i].e_valid) check($sformatf("vec%0d_pkt", i), 32'(pkt), 32'(vt[i].e_pkt));
      check($sformatf("vec%0d_ready", i), 32'(ready), 32'(vt[i].e_ready));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].e_err));
      check($sformatf("vec%0d_txc", i), 32'(txc), 32'(vt[i].e_txc));
    end
    set_idle();

    // Overfill the TX FIFO with ack held low, then drain with single-cycle acks
    for (int i = 0; i < 5; i++) begin
      req = 1; addr = 4'h3; typ = 1'(i); sdata = (i < 4) ? exp_order[i] : 24'd3;
      step();
      if (i == 3) check("full_ready", 32'(ready), 32'h0);
    end
    check("fifth_err", 32'(err), 32'h1);
    check("fifth_ready", 32'(ready), 32'h0);
    req = 0;
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      while (!valid && waited < 20) begin
        step();
        waited++;
      end
      check($sformatf("drain%0d_valid", k), 32'(valid), 32'h1);
      if (k > 0) check($sformatf("drain%0d_gap_ge2", k), 32'(waited >= 2), 32'h1);
      check($sformatf("drain%0d_data", k), 32'(pkt[23:0]), 32'(exp_order[k]));
      check($sformatf("drain%0d_addr", k), 32'(pkt[28:25]), 32'h3);
      ack = 1;
      step();
      check($sformatf("drain%0d_low", k), 32'(valid), 32'h0);
      ack = 0;
    end
    check("drain_txc", 32'(txc), 32'd5);

    // Stall indication on an offer that is never acked
    req = 1; addr = 4'h5; sdata = 24'h777;
    step();
    req = 0;
    waited = 0;
    while (!valid && waited < 20) begin
      step();
      waited++;
    end
    check("stall_offer_valid", 32'(valid), 32'h1);
    for (int c = 1; c <= 12; c++) begin
      step();
      check($sformatf("stall_c%0d", c), 32'(stall), 32'(c >= STALL));
    end
    ack = 1;
    step();
    check("stall_cleared", 32'(stall), 32'h0);
    ack = 0;
    step();

    // RX overflow, then accept-at-full with a simultaneous pop
    for (int i = 0; i < 5; i++) begin
      ptnv = 1; ptn = 24'h45 + 24'(i);
      step();
    end
    ptnv = 0;
    check("rx_full_count", 32'(rxc), 32'd4);
    check("rx_full_ovf", 32'(ovf), 32'h1);
    check("rx_full_head", 32'(rxd), 32'h45);
    ptnv = 1; ptn = 24'h50; pop = 1;
    step();
    ptnv = 0;
    check("rx_popfull_count", 32'(rxc), 32'd5);
    check("rx_popfull_ovf", 32'(ovf), 32'h1);
    check("rx_popfull_head", 32'(rxd), 32'h46);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rx_drain%0d", i), 32'(rxd), 32'(exp_drain[i]));
    end
    step();
    check("rx_drained_valid", 32'(rxv), 32'h0);
    pop = 0;

    // Reset while offering with three packets queued
    for (int i = 0; i < 3; i++) begin
      req = 1; addr = 4'h6; sdata = 24'h100 + 24'(i);
      step();
    end
    req = 0;
    step();
    check("pre_reset_valid", 32'(valid), 32'h1);
    rst = 1;
    step();
    rst = 0;
    check_reset_values("midreset");

    // Randomized traffic against the model
    ack_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       ack_pct = 5;
          1:       ack_pct = 50;
          default: ack_pct = 95;
        endcase
      end
      rst   = ($urandom_range(0, 999) == 0);
      req   = 1'($urandom_range(0, 1));
      addr  = 4'($urandom_range(0, 15));
      typ   = 1'($urandom_range(0, 1));
      sdata = 24'($urandom);
      ack   = ($urandom_range(0, 99) < ack_pct);
      ptnv  = ($urandom_range(0, 2) == 0);
      ptn   = 24'($urandom);
      pop   = 1'($urandom_range(0, 1));
      step();
    end
    rst = 0;
    set_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
